// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch front end.
//   - fetch_state_e : fetch FSM states (IDLE, WAIT, DROP)
//   - INST_W        : instruction word width
//   - PC_STEP       : byte distance between consecutive fetches
package fetch_pkg;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    WAIT = 2'd1,  // request outstanding, response will be kept
    DROP = 2'd2   // request outstanding, response will be discarded
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with a read-first head output.
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   push, wr_data   enqueue one entry (ignored when full)
//   pop             dequeue the head entry (ignored when empty)
//   flush           synchronous flush; empties the FIFO, wins over push/pop
//   rd_data         current head entry (don't-care when empty)
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full    = (count_r == CNT_FULL);
  assign empty   = (count_r == '0);
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];

  // Qualify push/pop against the occupancy flags.
  always_comb begin
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
  end

  // Storage, pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction-fetch front end. Issues one outstanding
// request at a time to instruction memory, buffers responses in a prefetch
// FIFO and hands them to decode over valid/ready. A redirect flushes the
// FIFO, restarts fetch at the new address and drops any in-flight response.
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   imem_req, imem_addr     registered fetch request, held until imem_ack
//   imem_ack, imem_data     memory response (may arrive in the request cycle)
//   inst_valid, inst_out,   FIFO head: instruction word and its fetch address
//   inst_pc
//   inst_ready              decode accepts the head entry
//   redirect, redirect_pc   one-cycle restart pulse and target (bits [1:0] ignored)
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int                CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));
  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] START_PC   = RESET_PC & ALIGN_MASK;

  fetch_state_e             state_r;
  fetch_state_e             state_nxt_s;
  logic [ADDR_W-1:0]        fetch_pc_r;
  logic                     imem_req_r;
  logic [ADDR_W-1:0]        imem_addr_r;

  logic                     issue_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     req_clr_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [CNT_W-1:0]         fifo_count_s;
  logic [ADDR_W+INST_W-1:0] fifo_head_s;

  assign imem_req   = imem_req_r;
  assign imem_addr  = imem_addr_r;
  assign inst_valid = !fifo_empty_s;
  assign inst_out   = fifo_head_s[INST_W-1:0];
  assign inst_pc    = fifo_head_s[INST_W +: ADDR_W];
  assign pop_s      = inst_valid && inst_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; a redirect overrides the normal transition.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (redirect) begin
          state_nxt_s = IDLE;
        end else if (fifo_count_s < DEPTH_C) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_nxt_s = IDLE;
        end else if (redirect) begin
          state_nxt_s = DROP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM outputs: issue decision, FIFO push and request retirement.
  // The issue decision uses the registered count, so a same-cycle dequeue
  // only frees a slot for the following cycle.
  always_comb begin
    issue_s   = 1'b0;
    push_s    = 1'b0;
    req_clr_s = 1'b0;
    case (state_r)
      IDLE: begin
        issue_s = !redirect && (fifo_count_s < DEPTH_C);
      end
      WAIT: begin
        push_s    = imem_ack && !redirect && !fifo_full_s;
        req_clr_s = imem_ack;
      end
      DROP: begin
        req_clr_s = imem_ack;
      end
      default: begin
        issue_s = 1'b0;
      end
    endcase
  end

  // Fetch PC and registered memory request/address.
  // imem_addr is captured separately from fetch_pc so it stays stable while
  // a dropped request is still outstanding after a redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_r  <= START_PC;
      imem_req_r  <= 1'b0;
      imem_addr_r <= START_PC;
    end else begin
      if (redirect) begin
        fetch_pc_r <= redirect_pc & ALIGN_MASK;
      end else if (push_s) begin
        fetch_pc_r <= fetch_pc_r + PC_INC;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end

      if (issue_s) begin
        imem_req_r  <= 1'b1;
        imem_addr_r <= fetch_pc_r;
      end else if (req_clr_s) begin
        imem_req_r  <= 1'b0;
        imem_addr_r <= imem_addr_r;
      end else begin
        imem_req_r  <= imem_req_r;
        imem_addr_r <= imem_addr_r;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (redirect),
    .wr_data ({imem_addr_r, imem_data}),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit. A behavioural memory answers requests with
// a configurable latency. The scoreboard keeps the program-order fetch
// address; each kept response pushes its expected {pc, word} and a monitor
// pops and compares on every dequeue. A second instance with a high reset
// address checks wrap-around of the fetch address.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_out, inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        imem_req2, imem_ack2, inst_valid2, inst_ready2, redirect2;
  logic [31:0] imem_addr2, imem_data2, inst_out2, inst_pc2, redirect_pc2;

  int          vecs = 0;
  int          errs = 0;
  int          min_lat = 0;
  int          max_lat = 0;

  // scoreboard state
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc = 32'h0;
  bit          stale = 1'b0;
  int          live_acks = 0;
  int          deq_cnt = 0;
  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  int          n2 = 0;
  logic [31:0] seq2 [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

  always #5 clk = ~clk;

  inst_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .inst_valid(inst_valid),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  inst_fetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_data(imem_data2), .inst_valid(inst_valid2),
    .inst_out(inst_out2), .inst_pc(inst_pc2), .inst_ready(inst_ready2),
    .redirect(redirect2), .redirect_pc(redirect_pc2)
  );

  function automatic logic [31:0] mix(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Behavioural instruction memory: answers a held request after a random latency.
  initial begin
    int  lat;
    bit  busy;
    lat = 0; busy = 1'b0;
    imem_ack = 1'b0; imem_data = 32'h0; imem_ack2 = 1'b0; imem_data2 = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          lat  = $urandom_range(max_lat, min_lat);
        end
        if (lat == 0) begin
          imem_ack = 1'b1; imem_data = mix(imem_addr); busy = 1'b0;
        end else begin
          imem_ack = 1'b0; imem_data = $urandom; lat--;
        end
      end else begin
        imem_ack = 1'b0; imem_data = $urandom; busy = 1'b0;
      end
      imem_ack2  = imem_req2;
      imem_data2 = mix(imem_addr2);
    end
  end

  // Monitor/scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      exp_q.delete();
      exp_pc   = 32'h0;
      stale    = 1'b0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      chk("inst_valid", {31'h0, inst_valid}, {31'h0, exp_q.size() != 0});
      if (imem_req) chk("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
      if (imem_req && prev_req && !prev_ack) chk("addr_stable", imem_addr, prev_addr);
      if (inst_valid && inst_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e[63:32]);
        chk("inst_out", inst_out, e[31:0]);
        deq_cnt++;
      end
      if (imem_req) begin
        if (redirect) stale = 1'b1;
        if (imem_ack) begin
          if (!stale) begin
            chk("fetch_addr", imem_addr, exp_pc);
            exp_q.push_back({exp_pc, mix(exp_pc)});
            exp_pc = exp_pc + 32'd4;
            live_acks++;
          end
          stale = 1'b0;
        end
      end
      if (redirect) begin
        exp_q.delete();
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      if (imem_req2 && imem_ack2 && n2 < 3) begin
        chk("wrap_seq", imem_addr2, seq2[n2]);
        n2++;
      end
    end
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "timeout");
  end

  // Directed and random stimulus.
  initial begin
    bit got;
    bit seen_low;
    reset = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    inst_ready2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = 32'h0;
    repeat (3) step();

    // reset state
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_addr2", imem_addr2, 32'hFFFF_FFF8);

    // zero-wait streaming, 1 instruction every 2 cycles
    reset = 1'b1; inst_ready = 1'b1; min_lat = 0; max_lat = 0;
    repeat (10) step();
    live_acks = 0;
    repeat (20) step();
    chk("zero_wait_rate", live_acks, 32'd10);

    // full FIFO: exactly DEPTH requests, then a dequeue re-opens fetch
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0; live_acks = 0;
    step();
    redirect = 1'b0;
    repeat (30) step();
    chk("full_req_count", live_acks, 32'd4);
    chk("full_req_idle", {31'h0, imem_req}, 32'h0);
    inst_ready = 1'b1;
    step();
    got = 1'b0;
    for (int i = 0; i < 3 && !got; i++) begin
      if (imem_req) got = 1'b1;
      else step();
    end
    chk("req_after_deq", {31'h0, got}, 32'h1);
    chk("req_after_deq_addr", imem_addr, 32'h10);
    repeat (10) step();

    // 3 wait states, redirect to 0x40 while waiting
    min_lat = 3; max_lat = 3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (imem_req && !imem_ack) got = 1'b1;
      else step();
    end
    chk("wait_found", {31'h0, got}, 32'h1);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("drop_holds_req", {31'h0, imem_req}, 32'h1);
    got = 1'b0; seen_low = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (!imem_req) seen_low = 1'b1;
      else if (seen_low) got = 1'b1;
      if (!got) step();
    end
    chk("redirect_req", {31'h0, got}, 32'h1);
    chk("redirect_addr", imem_addr, 32'h40);
    repeat (20) step();

    // redirect to 0x102 together with an ack and a dequeue
    min_lat = 0; max_lat = 0; inst_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (imem_req && imem_ack && inst_valid) got = 1'b1;
      else step();
    end
    chk("ack_deq_found", {31'h0, got}, 32'h1);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0; inst_ready = 1'b0;
    chk("flush_valid", {31'h0, inst_valid}, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      if (imem_req) got = 1'b1;
      else step();
    end
    chk("redir102_req", {31'h0, got}, 32'h1);
    chk("redir102_addr", imem_addr, 32'h100);
    inst_ready = 1'b1;
    repeat (10) step();

    // reset while waiting with two buffered entries
    inst_ready = 1'b0; min_lat = 3; max_lat = 3;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (exp_q.size() == 2 && imem_req && !imem_ack) got = 1'b1;
      else step();
    end
    chk("two_entries_found", {31'h0, got}, 32'h1);
    reset = 1'b0;
    step();
    chk("midrst_req", {31'h0, imem_req}, 32'h0);
    chk("midrst_valid", {31'h0, inst_valid}, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    reset = 1'b1;

    // randomized traffic
    min_lat = 0; max_lat = 3; deq_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      inst_ready  = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 40) == 0);
      redirect_pc = $urandom;
      step();
    end
    redirect = 1'b0; inst_ready = 1'b1;
    repeat (30) step();
    chk("progress", {31'h0, deq_cnt > 100}, 32'h1);
    chk("wrap_seen", n2, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
